// File: rtl/swivm_pkg.sv
// Shared encodings for the SwiVM memory arbiter: grant ids, FSM states and
// the legal memory-latency range.
package swivm_pkg;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_LD   = 2'd1;
   localparam logic [1:0] GNT_DP   = 2'd2;
   localparam logic [1:0] GNT_IF   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/swivm_arb_pick.sv
// Combinational winner select: LD has absolute priority, DP/IF alternate on a
// tie using the id of the last DP/IF winner.
module swivm_arb_pick
   import swivm_pkg::*;
(
   input  logic       i_ld_req,
   input  logic       i_dp_req,
   input  logic       i_if_req,
   input  logic [1:0] i_rr_last,
   output logic [1:0] o_win
);

   always_comb begin
      o_win = GNT_NONE;
      if (i_ld_req)
         o_win = GNT_LD;
      else if (i_dp_req && i_if_req)
         o_win = (i_rr_last == GNT_DP) ? GNT_IF : GNT_DP;
      else if (i_dp_req)
         o_win = GNT_DP;
      else if (i_if_req)
         o_win = GNT_IF;
   end

endmodule

// File: rtl/swivm_mem_arbiter.sv
// Single-port memory arbiter for SwiVM: serialises LD / DP / IF accesses,
// one transaction in flight, all outputs registered.
module swivm_mem_arbiter
   import swivm_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ld_req,
   input  logic          dp_req,
   input  logic          if_req,
   input  logic          ld_we,
   input  logic          dp_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [AW-1:0] dp_addr,
   input  logic [AW-1:0] if_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic [DW-1:0] dp_wdata,
   output logic          ld_ack,
   output logic          dp_ack,
   output logic          if_ack,
   output logic [DW-1:0] rd_data,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    gnt_id,
   output logic          busy
);

   localparam int CW = $clog2(MEM_LAT_MAX);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("swivm_mem_arbiter: MEM_LAT out of range");
   end

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic            r_we;
   logic [1:0]      r_rr_last;
   logic [1:0]      w_win;
   logic            w_grant;
   logic            w_last_wait;
   logic            w_sel_we;
   logic [AW-1:0]   w_sel_addr;
   logic [DW-1:0]   w_sel_wdata;

   swivm_arb_pick u_pick (
      .i_ld_req  (ld_req),
      .i_dp_req  (dp_req),
      .i_if_req  (if_req),
      .i_rr_last (r_rr_last),
      .o_win     (w_win)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Requests are only looked at in IDLE, so a req still high during ACK is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_last_wait = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_win != GNT_NONE) begin
               w_grant     = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_last_wait = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         S_ACK:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // IF is read-only and carries no write data, so the write bus keeps its value.
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = mem_addr;
      w_sel_wdata = mem_wdata;
      case (w_win)
         GNT_LD: begin
            w_sel_we    = ld_we;
            w_sel_addr  = ld_addr;
            w_sel_wdata = ld_wdata;
         end
         GNT_DP: begin
            w_sel_we    = dp_we;
            w_sel_addr  = dp_addr;
            w_sel_wdata = dp_wdata;
         end
         GNT_IF:  w_sel_addr = if_addr;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_rr_last <= GNT_IF;
         gnt_id    <= GNT_NONE;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_data   <= '0;
         ld_ack    <= 1'b0;
         dp_ack    <= 1'b0;
         if_ack    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mem_en <= w_grant;
         mem_we <= w_grant & w_sel_we;
         if (w_grant) begin
            gnt_id    <= w_win;
            r_we      <= w_sel_we;
            mem_addr  <= w_sel_addr;
            mem_wdata <= w_sel_wdata;
            if (w_win != GNT_LD) r_rr_last <= w_win;
         end else if (r_state == S_ACK) begin
            gnt_id <= GNT_NONE;
         end

         if (r_state == S_ISSUE)
            r_cnt <= CW'(MEM_LAT - 1);
         else if (r_state == S_WAIT && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;

         if (w_last_wait && !r_we) rd_data <= mem_rdata;

         ld_ack <= w_last_wait && (gnt_id == GNT_LD);
         dp_ack <= w_last_wait && (gnt_id == GNT_DP);
         if_ack <= w_last_wait && (gnt_id == GNT_IF);
         busy   <= (w_state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_swivm_mem_arbiter.sv
// Directed bench for swivm_mem_arbiter: a MEM_LAT=1 instance against a small
// synchronous memory, and a MEM_LAT=3 instance fed a cycle-stamped read bus.
module tb_swivm_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        ld_req, dp_req, if_req, ld_we, dp_we;
   logic [15:0] ld_addr, dp_addr, if_addr, ld_wdata, dp_wdata;
   logic        ld_ack, dp_ack, if_ack, mem_en, mem_we, busy;
   logic [15:0] rd_data, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  gnt_id;

   logic        ld_req_3, dp_req_3, if_req_3, ld_we_3, dp_we_3;
   logic [15:0] ld_addr_3, dp_addr_3, if_addr_3, ld_wdata_3, dp_wdata_3;
   logic        ld_ack_3, dp_ack_3, if_ack_3, mem_en_3, mem_we_3, busy_3;
   logic [15:0] rd_data_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
   logic [1:0]  gnt_id_3;

   logic [15:0] mem [0:4095];
   logic [15:0] mem_q;
   logic [15:0] cyc;
   int          ntests = 0;
   int          nfail  = 0;

   swivm_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .ld_req(ld_req), .dp_req(dp_req), .if_req(if_req),
      .ld_we(ld_we), .dp_we(dp_we),
      .ld_addr(ld_addr), .dp_addr(dp_addr), .if_addr(if_addr),
      .ld_wdata(ld_wdata), .dp_wdata(dp_wdata),
      .ld_ack(ld_ack), .dp_ack(dp_ack), .if_ack(if_ack),
      .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .gnt_id(gnt_id), .busy(busy)
   );

   swivm_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n),
      .ld_req(ld_req_3), .dp_req(dp_req_3), .if_req(if_req_3),
      .ld_we(ld_we_3), .dp_we(dp_we_3),
      .ld_addr(ld_addr_3), .dp_addr(dp_addr_3), .if_addr(if_addr_3),
      .ld_wdata(ld_wdata_3), .dp_wdata(dp_wdata_3),
      .ld_ack(ld_ack_3), .dp_ack(dp_ack_3), .if_ack(if_ack_3),
      .rd_data(rd_data_3), .mem_en(mem_en_3), .mem_we(mem_we_3),
      .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3),
      .gnt_id(gnt_id_3), .busy(busy_3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle synchronous memory; a few words are preloaded while in reset.
   always @(posedge clk) begin
      if (!reset_n) begin
         mem[12'h010] <= 16'hBEEF;
         mem[12'h020] <= 16'h5A5A;
         mem[12'h030] <= 16'h0F0F;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
         else        mem_q <= mem[mem_addr[11:0]];
      end
   end
   assign mem_rdata = mem_q;

   always @(posedge clk) begin
      if (!reset_n) cyc <= 16'd0;
      else          cyc <= cyc + 16'd1;
   end
   assign mem_rdata_3 = {4'hC, cyc[11:0]};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  exp_ack;
      logic [15:0] issue_cyc;
      logic [15:0] e;

      reset_n = 1'b0;
      {ld_req, dp_req, if_req, ld_we, dp_we} = '0;
      {ld_addr, dp_addr, if_addr, ld_wdata, dp_wdata} = '0;
      {ld_req_3, dp_req_3, if_req_3, ld_we_3, dp_we_3} = '0;
      {ld_addr_3, dp_addr_3, if_addr_3, ld_wdata_3, dp_wdata_3} = '0;
      repeat (3) tick();
      check("reset_ctl", {gnt_id, busy, mem_en, mem_we, ld_ack, dp_ack, if_ack}, 32'd0);
      check("reset_rd", rd_data, 32'd0);
      check("reset_addr", {mem_addr, mem_wdata}, 32'd0);
      reset_n = 1'b1;
      tick();

      // Single DP read of 0x0010
      dp_addr = 16'h0010; dp_req = 1'b1;
      tick();
      check("dp_issue", {gnt_id, busy, mem_en, mem_we}, {28'd0, 2'd2, 1'b1, 1'b1, 1'b0});
      check("dp_issue_addr", mem_addr, 32'h0010);
      tick();
      check("dp_wait", {mem_en, ld_ack, dp_ack, if_ack}, 32'd0);
      tick();
      check("dp_ack", {ld_ack, dp_ack, if_ack}, 32'b010);
      check("dp_rd", rd_data, 32'hBEEF);
      dp_req = 1'b0;
      tick();
      check("dp_idle", {gnt_id, busy, ld_ack, dp_ack, if_ack}, 32'd0);

      // LD write 0x1234 to 0x0100, then IF read back
      ld_addr = 16'h0100; ld_wdata = 16'h1234; ld_we = 1'b1; ld_req = 1'b1;
      tick();
      check("ld_issue", {gnt_id, mem_en, mem_we}, {28'd0, 2'd1, 1'b1, 1'b1});
      check("ld_issue_bus", {mem_addr, mem_wdata}, {16'h0100, 16'h1234});
      tick();
      check("ld_we_drop", {mem_en, mem_we}, 32'd0);
      tick();
      check("ld_ack", {ld_ack, dp_ack, if_ack}, 32'b100);
      check("ld_rd_hold", rd_data, 32'hBEEF);
      ld_req = 1'b0; ld_we = 1'b0;
      tick();
      if_addr = 16'h0100; if_req = 1'b1;
      tick();
      check("if_issue", {gnt_id, mem_en, mem_we}, {28'd0, 2'd3, 1'b1, 1'b0});
      tick();
      tick();
      check("if_ack", {ld_ack, dp_ack, if_ack}, 32'b001);
      check("if_rd", rd_data, 32'h1234);
      if_req = 1'b0;
      tick();
      check("addr_hold", mem_addr, 32'h0100);

      // DP and IF held together: alternate, one ack every 4 cycles
      dp_addr = 16'h0010; if_addr = 16'h0020; dp_req = 1'b1; if_req = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         tick();
         exp_ack = 3'b000;
         if (c % 4 == 3) exp_ack = ((c / 4) % 2 == 0) ? 3'b010 : 3'b001;
         check($sformatf("rr_ack_c%0d", c), {ld_ack, dp_ack, if_ack}, {29'd0, exp_ack});
         if (c % 4 == 1)
            check($sformatf("rr_gnt_c%0d", c), gnt_id, ((c / 4) % 2 == 0) ? 32'd2 : 32'd3);
         if (c % 4 == 3)
            check($sformatf("rr_rd_c%0d", c), rd_data, ((c / 4) % 2 == 0) ? 32'hBEEF : 32'h5A5A);
         if (c == 15) begin dp_req = 1'b0; if_req = 1'b0; end
      end
      tick();
      check("rr_idle", busy, 32'd0);

      // All three together: LD, then DP, then IF
      ld_addr = 16'h0030; ld_we = 1'b0;
      ld_req = 1'b1; dp_req = 1'b1; if_req = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         exp_ack = (c == 3) ? 3'b100 : (c == 7) ? 3'b010 : (c == 11) ? 3'b001 : 3'b000;
         check($sformatf("all_ack_c%0d", c), {ld_ack, dp_ack, if_ack}, {29'd0, exp_ack});
         if (c == 1) check("all_gnt_ld", gnt_id, 32'd1);
         if (c == 5) check("all_gnt_dp", gnt_id, 32'd2);
         if (c == 9) check("all_gnt_if", gnt_id, 32'd3);
         if (c == 3)  begin check("all_rd_ld", rd_data, 32'h0F0F); ld_req = 1'b0; end
         if (c == 7)  begin check("all_rd_dp", rd_data, 32'hBEEF); dp_req = 1'b0; end
         if (c == 11) begin check("all_rd_if", rd_data, 32'h5A5A); if_req = 1'b0; end
      end
      tick();

      // MEM_LAT=3 instance: ack at T+5, data sampled in the third WAIT cycle
      dp_addr_3 = 16'h0040; dp_req_3 = 1'b1;
      tick();
      check("l3_issue", {mem_en_3, mem_addr_3}, {15'd0, 1'b1, 16'h0040});
      issue_cyc = cyc;
      repeat (3) tick();
      check("l3_no_early_ack", dp_ack_3, 32'd0);
      tick();
      check("l3_ack", {ld_ack_3, dp_ack_3, if_ack_3}, 32'b010);
      e = issue_cyc + 16'd3;
      check("l3_rd", rd_data_3, {16'd0, 4'hC, e[11:0]});
      dp_req_3 = 1'b0;
      tick();
      check("l3_ack_drop", dp_ack_3, 32'd0);

      // Reset during WAIT abandons the transaction
      dp_addr = 16'h0010; dp_req = 1'b1;
      tick();
      tick();
      check("rst_pre_busy", {busy, gnt_id}, {29'd0, 1'b1, 2'd2});
      reset_n = 1'b0;
      #1;
      check("rst_async_ctl", {gnt_id, busy, mem_en, mem_we, ld_ack, dp_ack, if_ack}, 32'd0);
      check("rst_async_rd", rd_data, 32'd0);
      dp_req = 1'b0;
      tick();
      check("rst_hold_ack", {ld_ack, dp_ack, if_ack}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      check("rst_post_ack", {busy, ld_ack, dp_ack, if_ack}, 32'd0);

      // After reset DP wins the first tie, then IF completes normally
      dp_addr = 16'h0010; if_addr = 16'h0020; dp_req = 1'b1; if_req = 1'b1;
      tick();
      check("post_gnt_dp", gnt_id, 32'd2);
      tick();
      tick();
      check("post_ack_dp", {ld_ack, dp_ack, if_ack}, 32'b010);
      dp_req = 1'b0;
      tick();
      tick();
      check("post_gnt_if", gnt_id, 32'd3);
      tick();
      tick();
      check("post_ack_if", {ld_ack, dp_ack, if_ack}, 32'b001);
      check("post_rd_if", rd_data, 32'h5A5A);
      if_req = 1'b0;
      tick();
      check("post_idle", {busy, gnt_id}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
